// File: rtl/core_pkg.sv
// Shared core definitions: machine width and the memory-arbiter
// state and owner encodings used by the unified memory port.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    OWN_I,
    OWN_D
  } mem_owner_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory signals around the arbiter.
// slave = arbiter side, master = core plus memory side.
import core_pkg::*;

interface core_mem_arbiter_if #(
  parameter int ADDR_W = XLEN,
  parameter int DATA_W = XLEN
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_ready;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_ready;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_ready,
    output if_rvalid,
    output if_rdata,
    input  d_req,
    input  d_we,
    input  d_addr,
    input  d_wdata,
    input  d_wstrb,
    output d_ready,
    output d_rvalid,
    output d_rdata,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_ready,
    input  if_rvalid,
    input  if_rdata,
    output d_req,
    output d_we,
    output d_addr,
    output d_wdata,
    output d_wstrb,
    input  d_ready,
    input  d_rvalid,
    input  d_rdata,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between
// instruction fetch and load/store, one access in flight at a time.
module core_mem_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W  = XLEN,
  parameter int DATA_W  = XLEN,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  core_mem_arbiter_if.slave    bus
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
    $error("core_mem_arbiter: MEM_LAT=%0d outside 1..15", MEM_LAT);
  end

  if (DATA_W % 8 != 0) begin : g_dw_chk
    $error("core_mem_arbiter: DATA_W=%0d not byte multiple", DATA_W);
  end

  if (ADDR_W < 2) begin : g_aw_chk
    $error("core_mem_arbiter: ADDR_W=%0d too small", ADDR_W);
  end

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  arb_state_e  r_state;
  mem_owner_e  r_owner;
  mem_owner_e  r_last_owner;
  logic [3:0]  r_cnt;
  logic        r_we;

  logic        w_resp;
  logic        w_can;
  logic        w_win_d;
  logic        w_gnt_i;
  logic        w_gnt_d;
  mem_owner_e  w_winner;

  assign w_resp = (r_state == ARB_BUSY) && (r_cnt == 4'd1);

  // The response cycle doubles as a grant slot for full throughput.
  assign w_can = !rst && ((r_state == ARB_IDLE) || w_resp);

  assign w_win_d = bus.d_req &&
                   (!bus.if_req || (r_last_owner == OWN_I));

  assign w_gnt_d  = w_can && w_win_d;
  assign w_gnt_i  = w_can && bus.if_req && !w_win_d;
  assign w_winner = w_gnt_d ? OWN_D : OWN_I;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWN_I;
      r_last_owner <= OWN_D;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
    end else if (w_gnt_i || w_gnt_d) begin
      r_state      <= ARB_BUSY;
      r_owner      <= w_winner;
      r_last_owner <= w_winner;
      r_cnt        <= LAT;
      r_we         <= w_gnt_d && bus.d_we;
    end else if (r_state == ARB_BUSY) begin
      r_cnt <= r_cnt - 4'd1;
      if (w_resp) begin
        r_state <= ARB_IDLE;
      end
    end
  end

  assign bus.if_ready = w_gnt_i;
  assign bus.d_ready  = w_gnt_d;
  assign bus.mem_en   = w_gnt_i || w_gnt_d;
  assign bus.busy     = (r_state == ARB_BUSY);

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    unique case (1'b1)
      w_gnt_d: begin
        bus.mem_we    = bus.d_we;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.mem_wstrb = bus.d_we ? bus.d_wstrb : '0;
      end
      w_gnt_i: begin
        bus.mem_addr = bus.if_addr;
      end
      default: begin
        bus.mem_we = 1'b0;
      end
    endcase
  end

  // Store acks carry no data even though the memory bus may.
  always_comb begin
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = '0;
    unique case (1'b1)
      w_resp && (r_owner == OWN_I): begin
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = bus.mem_rdata;
      end
      w_resp && (r_owner == OWN_D): begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = r_we ? '0 : bus.mem_rdata;
      end
      default: begin
        bus.if_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter with latency-2 and latency-1
// instances, behavioural memories and per-requester scoreboards.
module tb_core_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ia ();
  core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  logic [31:0] mem_a [256] = '{2: 32'h0050_0093, default: 32'h0};
  logic [31:0] mem_b [256] = '{0: 32'h1000, 1: 32'h1001,
                               2: 32'h1002, 3: 32'h1003,
                               default: 32'h0};
  logic [31:0] pa0 = 32'h0;
  logic [31:0] pa1 = 32'h0;
  logic [31:0] pb0 = 32'h0;

  always @(posedge clk) begin
    pa1 <= pa0;
    pa0 <= ia.mem_en ? mem_a[ia.mem_addr[9:2]] : 32'h0;
    if (ia.mem_en && ia.mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (ia.mem_wstrb[k])
          mem_a[ia.mem_addr[9:2]][8*k +: 8] <= ia.mem_wdata[8*k +: 8];
      end
    end
  end

  always @(posedge clk) begin
    pb0 <= ib.mem_en ? mem_b[ib.mem_addr[9:2]] : 32'h0;
  end

  assign ia.mem_rdata = pa1;
  assign ib.mem_rdata = pb0;

  logic [31:0] qi [$];
  logic [31:0] qd [$];
  logic [31:0] exp_v;
  int n_pass  = 0;
  int n_total = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ia.if_req = 1'b1;
    ia.d_req  = 1'b1;
    step();
    step();
    #1;
    n_total++;
    if (ia.if_ready !== 1'b0) $display("FAIL rst_if_ready got %b exp 0", ia.if_ready);
    else n_pass++;
    n_total++;
    if (ia.d_ready !== 1'b0) $display("FAIL rst_d_ready got %b exp 0", ia.d_ready);
    else n_pass++;
    n_total++;
    if (ia.mem_en !== 1'b0) $display("FAIL rst_mem_en got %b exp 0", ia.mem_en);
    else n_pass++;
    n_total++;
    if (ia.busy !== 1'b0 || ib.busy !== 1'b0)
      $display("FAIL rst_busy got %b/%b exp 0/0", ia.busy, ib.busy);
    else n_pass++;
    n_total++;
    if (ia.mem_addr !== 32'h0) $display("FAIL rst_mem_addr got %h exp 0", ia.mem_addr);
    else n_pass++;
    ia.if_req = 1'b0;
    ia.d_req  = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    ia.if_req  = 1'b1;
    ia.if_addr = 32'h8;
    #1;
    n_total++;
    if (ia.if_ready !== 1'b1 || ia.mem_en !== 1'b1)
      $display("FAIL fetch_grant got rdy=%b en=%b exp 1/1", ia.if_ready, ia.mem_en);
    else n_pass++;
    n_total++;
    if (ia.mem_addr !== 32'h8 || ia.mem_we !== 1'b0 || ia.mem_wstrb !== 4'h0)
      $display("FAIL fetch_bus got a=%h we=%b s=%h exp 8/0/0",
               ia.mem_addr, ia.mem_we, ia.mem_wstrb);
    else n_pass++;
    qi.push_back(32'h0050_0093);
    step();
    ia.if_req = 1'b0;
    #1;
    n_total++;
    if (ia.busy !== 1'b1 || ia.if_rvalid !== 1'b0)
      $display("FAIL fetch_t1 got busy=%b rv=%b exp 1/0", ia.busy, ia.if_rvalid);
    else n_pass++;
    step();
    #1;
    n_total++;
    if (ia.busy !== 1'b1 || ia.if_rvalid !== 1'b1)
      $display("FAIL fetch_t2 got busy=%b rv=%b exp 1/1", ia.busy, ia.if_rvalid);
    else n_pass++;
    n_total++;
    if (qi.size() == 0) $display("FAIL fetch_data got rdata=%h exp none", ia.if_rdata);
    else begin
      exp_v = qi.pop_front();
      if (ia.if_rdata !== exp_v) $display("FAIL fetch_data got %h exp %h", ia.if_rdata, exp_v);
      else n_pass++;
    end
    step();
    #1;
    n_total++;
    if (ia.busy !== 1'b0 || ia.if_rvalid !== 1'b0)
      $display("FAIL fetch_t3 got busy=%b rv=%b exp 0/0", ia.busy, ia.if_rvalid);
    else n_pass++;
  endtask

  task automatic test_store_load();
    ia.d_req   = 1'b1;
    ia.d_we    = 1'b1;
    ia.d_addr  = 32'h40;
    ia.d_wdata = 32'hDEAD_BEEF;
    ia.d_wstrb = 4'b0011;
    #1;
    n_total++;
    if (ia.d_ready !== 1'b1 || ia.mem_we !== 1'b1 || ia.mem_wstrb !== 4'b0011)
      $display("FAIL store_grant got rdy=%b we=%b s=%b exp 1/1/0011",
               ia.d_ready, ia.mem_we, ia.mem_wstrb);
    else n_pass++;
    qd.push_back(32'h0);
    step();
    ia.d_we    = 1'b0;
    ia.d_wstrb = 4'b0000;
    #1;
    n_total++;
    if (ia.d_ready !== 1'b0) $display("FAIL load_wait got rdy=%b exp 0", ia.d_ready);
    else n_pass++;
    step();
    #1;
    n_total++;
    if (ia.d_rvalid !== 1'b1) $display("FAIL store_ack got rv=%b exp 1", ia.d_rvalid);
    else n_pass++;
    n_total++;
    if (qd.size() == 0) $display("FAIL store_data got %h exp none", ia.d_rdata);
    else begin
      exp_v = qd.pop_front();
      if (ia.d_rdata !== exp_v) $display("FAIL store_data got %h exp %h", ia.d_rdata, exp_v);
      else n_pass++;
    end
    n_total++;
    if (ia.d_ready !== 1'b1 || ia.mem_we !== 1'b0 || ia.mem_wstrb !== 4'h0)
      $display("FAIL load_grant got rdy=%b we=%b s=%h exp 1/0/0",
               ia.d_ready, ia.mem_we, ia.mem_wstrb);
    else n_pass++;
    qd.push_back(32'h0000_BEEF);
    step();
    ia.d_req = 1'b0;
    step();
    #1;
    n_total++;
    if (ia.d_rvalid !== 1'b1) $display("FAIL load_rv got %b exp 1", ia.d_rvalid);
    else n_pass++;
    n_total++;
    if (qd.size() == 0) $display("FAIL load_data got %h exp none", ia.d_rdata);
    else begin
      exp_v = qd.pop_front();
      if (ia.d_rdata !== exp_v) $display("FAIL load_data got %h exp %h", ia.d_rdata, exp_v);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_zero_strobe();
    ia.d_req   = 1'b1;
    ia.d_we    = 1'b1;
    ia.d_addr  = 32'h40;
    ia.d_wdata = 32'hFFFF_FFFF;
    ia.d_wstrb = 4'b0000;
    #1;
    n_total++;
    if (ia.mem_en !== 1'b1 || ia.mem_wstrb !== 4'h0 || ia.d_ready !== 1'b1)
      $display("FAIL zstrb_grant got en=%b s=%h rdy=%b exp 1/0/1",
               ia.mem_en, ia.mem_wstrb, ia.d_ready);
    else n_pass++;
    qd.push_back(32'h0);
    step();
    ia.d_req = 1'b0;
    ia.d_we  = 1'b0;
    step();
    #1;
    n_total++;
    if (ia.d_rvalid !== 1'b1) $display("FAIL zstrb_ack got %b exp 1", ia.d_rvalid);
    else n_pass++;
    n_total++;
    if (qd.size() == 0) $display("FAIL zstrb_data got %h exp none", ia.d_rdata);
    else begin
      exp_v = qd.pop_front();
      if (ia.d_rdata !== exp_v) $display("FAIL zstrb_data got %h exp %h", ia.d_rdata, exp_v);
      else n_pass++;
    end
    step();
    n_total++;
    if (mem_a[16] !== 32'h0000_BEEF)
      $display("FAIL zstrb_mem got %h exp 0000beef", mem_a[16]);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic gi, gd, ri, rd;
    int k;
    rst = 1'b1;
    ia.if_req = 1'b0;
    ia.d_req  = 1'b0;
    step();
    rst = 1'b0;
    ia.if_addr = 32'h8;
    ia.d_addr  = 32'h40;
    ia.d_we    = 1'b0;
    ia.d_wstrb = 4'h0;
    for (int c = 0; c < 10; c++) begin
      ia.if_req = (c < 7);
      ia.d_req  = (c < 7);
      #1;
      gi = (c < 8) && (c % 2 == 0) && ((c / 2) % 2 == 0);
      gd = (c < 8) && (c % 2 == 0) && ((c / 2) % 2 == 1);
      k  = (c - 2) / 2;
      ri = (c >= 2) && (c <= 8) && (c % 2 == 0) && (k % 2 == 0);
      rd = (c >= 2) && (c <= 8) && (c % 2 == 0) && (k % 2 == 1);
      n_total++;
      if (ia.if_ready !== gi || ia.d_ready !== gd)
        $display("FAIL cont_grant c=%0d got i=%b d=%b exp i=%b d=%b",
                 c, ia.if_ready, ia.d_ready, gi, gd);
      else n_pass++;
      n_total++;
      if (ia.if_rvalid !== ri || ia.d_rvalid !== rd)
        $display("FAIL cont_rvalid c=%0d got i=%b d=%b exp i=%b d=%b",
                 c, ia.if_rvalid, ia.d_rvalid, ri, rd);
      else n_pass++;
      if (ri) begin
        n_total++;
        if (qi.size() == 0) $display("FAIL cont_idata c=%0d got %h exp none", c, ia.if_rdata);
        else begin
          exp_v = qi.pop_front();
          if (ia.if_rdata !== exp_v)
            $display("FAIL cont_idata c=%0d got %h exp %h", c, ia.if_rdata, exp_v);
          else n_pass++;
        end
      end
      if (rd) begin
        n_total++;
        if (qd.size() == 0) $display("FAIL cont_ddata c=%0d got %h exp none", c, ia.d_rdata);
        else begin
          exp_v = qd.pop_front();
          if (ia.d_rdata !== exp_v)
            $display("FAIL cont_ddata c=%0d got %h exp %h", c, ia.d_rdata, exp_v);
          else n_pass++;
        end
      end
      if (gi) qi.push_back(32'h0050_0093);
      if (gd) qd.push_back(32'h0000_BEEF);
      step();
    end
  endtask

  task automatic test_reset_mid();
    ia.if_req  = 1'b1;
    ia.if_addr = 32'h8;
    #1;
    n_total++;
    if (ia.if_ready !== 1'b1) $display("FAIL rmid_grant got %b exp 1", ia.if_ready);
    else n_pass++;
    step();
    ia.if_req = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if (ia.busy !== 1'b0 || ia.mem_en !== 1'b0 || ia.if_rvalid !== 1'b0 ||
        ia.if_rdata !== 32'h0 || ia.mem_addr !== 32'h0)
      $display("FAIL rmid_zero got busy=%b en=%b rv=%b rd=%h a=%h exp all 0",
               ia.busy, ia.mem_en, ia.if_rvalid, ia.if_rdata, ia.mem_addr);
    else n_pass++;
    step();
    #1;
    n_total++;
    if (ia.if_rvalid !== 1'b0) $display("FAIL rmid_norv got %b exp 0", ia.if_rvalid);
    else n_pass++;
    rst = 1'b0;
    ia.d_req  = 1'b1;
    ia.d_we   = 1'b0;
    ia.d_addr = 32'h8;
    #1;
    n_total++;
    if (ia.d_ready !== 1'b1 || ia.if_rvalid !== 1'b0)
      $display("FAIL rmid_regrant got rdy=%b irv=%b exp 1/0", ia.d_ready, ia.if_rvalid);
    else n_pass++;
    qd.push_back(32'h0050_0093);
    step();
    ia.d_req = 1'b0;
    step();
    #1;
    n_total++;
    if (ia.d_rvalid !== 1'b1 || ia.if_rvalid !== 1'b0)
      $display("FAIL rmid_rv got d=%b i=%b exp 1/0", ia.d_rvalid, ia.if_rvalid);
    else n_pass++;
    n_total++;
    if (qd.size() == 0) $display("FAIL rmid_data got %h exp none", ia.d_rdata);
    else begin
      exp_v = qd.pop_front();
      if (ia.d_rdata !== exp_v) $display("FAIL rmid_data got %h exp %h", ia.d_rdata, exp_v);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic er, ev;
    ib.d_we    = 1'b0;
    ib.d_wstrb = 4'h0;
    ib.d_wdata = 32'h0;
    for (int c = 0; c < 6; c++) begin
      ib.d_req  = (c < 4);
      ib.d_addr = 32'(4 * c);
      #1;
      er = (c < 4);
      ev = (c >= 1) && (c <= 4);
      n_total++;
      if (ib.d_ready !== er || ib.d_rvalid !== ev)
        $display("FAIL b2b c=%0d got rdy=%b rv=%b exp %b/%b",
                 c, ib.d_ready, ib.d_rvalid, er, ev);
      else n_pass++;
      if (ev) begin
        n_total++;
        if (qd.size() == 0) $display("FAIL b2b_data c=%0d got %h exp none", c, ib.d_rdata);
        else begin
          exp_v = qd.pop_front();
          if (ib.d_rdata !== exp_v)
            $display("FAIL b2b_data c=%0d got %h exp %h", c, ib.d_rdata, exp_v);
          else n_pass++;
        end
      end
      if (er) qd.push_back(32'h1000 + 32'(c));
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    ia.if_req = 1'b0; ia.if_addr = 32'h0;
    ia.d_req = 1'b0; ia.d_we = 1'b0; ia.d_addr = 32'h0;
    ia.d_wdata = 32'h0; ia.d_wstrb = 4'h0;
    ib.if_req = 1'b0; ib.if_addr = 32'h0;
    ib.d_req = 1'b0; ib.d_we = 1'b0; ib.d_addr = 32'h0;
    ib.d_wdata = 32'h0; ib.d_wstrb = 4'h0;
    test_reset();
    test_fetch();
    test_store_load();
    test_zero_strobe();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
